// File: rtl/dec_last_sig_xy.sv
// Last significant coefficient X/Y decode: sequences prefix context bins and bypass suffix bits for one transform block.
// Latency: start + 1 to first request, o_done the cycle after the final strobe (minimum start + 3).
// Backpressure: level requests o_dec_en/o_byp_en held until a strobe arrives; one request outstanding. Option: DEC_LAST_XY_BINCNT_EN.
module dec_last_sig_xy (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_start,
    input  logic [2:0] i_log2TrafoSize,
    input  logic [1:0] i_cIdx,
    input  logic [1:0] i_scanIdx,
    output logic       o_dec_en,
    output logic [5:0] o_cm_idx,
    input  logic       i_bin_valid,
    input  logic       i_binVal,
    output logic       o_byp_en,
    input  logic       i_byp_valid,
    input  logic       i_byp_bin,
    output logic       o_busy,
    output logic       o_done,
    output logic [4:0] o_last_x,
    output logic [4:0] o_last_y
`ifdef DEC_LAST_XY_BINCNT_EN
    ,
    output logic [4:0] o_bin_cnt
`endif
);

    typedef enum logic [2:0] {S_IDLE, S_XPRE, S_YPRE, S_XSUF, S_YSUF, S_DONE} state_t;

    state_t     state_q, state_d;
    logic [2:0] log2_q, log2_d;
    logic       chroma_q, chroma_d;
    logic       swap_q, swap_d;
    logic [3:0] bin_idx_q, bin_idx_d;
    logic [3:0] xpre_q, xpre_d, ypre_q, ypre_d;
    logic [2:0] xsuf_q, xsuf_d, ysuf_q, ysuf_d;
    logic [1:0] suf_cnt_q, suf_cnt_d;
    logic [4:0] last_x_q, last_x_d, last_y_q, last_y_d;

    logic [3:0] cmax;
    logic [5:0] l6, ctx_off, cm_raw;
    logic [1:0] ctx_sh;
    logic [4:0] pos_x, pos_y;

    // Suffix length (p >> 1) - 1, taking p >> 1 directly.
    function automatic logic [1:0] suf_len(input logic [2:0] p_half);
        return 2'(p_half - 3'd1);
    endfunction

    function automatic logic [4:0] last_pos(input logic [3:0] p, input logic [2:0] suf);
        logic [2:0] k;
        logic [4:0] base;
        if (p <= 4'd3) return {1'b0, p};
        k    = p[3:1] - 3'd1;
        base = {3'b000, 1'b1, p[0]} << k;
        return base + {2'b00, suf};
    endfunction

    assign cmax = {log2_q, 1'b0} - 4'd1;
    assign l6   = {3'b000, log2_q};

    always_comb begin
        ctx_off = 6'd15;
        ctx_sh  = 2'(log2_q - 3'd2);
        if (!chroma_q) begin
            ctx_off = ((l6 - 6'd2) * 6'd3) + ((l6 - 6'd1) >> 2);
            ctx_sh  = 2'((l6 + 6'd1) >> 2);
        end
    end

    assign cm_raw   = ({2'b00, bin_idx_q} >> ctx_sh) + ctx_off + ((state_q == S_YPRE) ? 6'd18 : 6'd0);
    assign o_dec_en = (state_q == S_XPRE) || (state_q == S_YPRE);
    assign o_byp_en = (state_q == S_XSUF) || (state_q == S_YSUF);
    assign o_cm_idx = o_dec_en ? cm_raw : 6'd0;
    assign o_busy   = (state_q != S_IDLE);
    assign o_done   = (state_q == S_DONE);
    assign o_last_x = last_x_q;
    assign o_last_y = last_y_q;

    always_comb begin
        state_d   = state_q;
        log2_d    = log2_q;
        chroma_d  = chroma_q;
        swap_d    = swap_q;
        bin_idx_d = bin_idx_q;
        xpre_d    = xpre_q;
        ypre_d    = ypre_q;
        xsuf_d    = xsuf_q;
        ysuf_d    = ysuf_q;
        suf_cnt_d = suf_cnt_q;
        case (state_q)
            S_IDLE: if (i_start) begin
                log2_d    = i_log2TrafoSize;
                chroma_d  = (i_cIdx != 2'd0);
                swap_d    = (i_scanIdx == 2'd2);
                bin_idx_d = '0;
                xpre_d    = '0;
                ypre_d    = '0;
                xsuf_d    = '0;
                ysuf_d    = '0;
                suf_cnt_d = '0;
                state_d   = S_XPRE;
            end
            S_XPRE: if (i_bin_valid) begin
                bin_idx_d = bin_idx_q + 4'd1;
                if (i_binVal) xpre_d = xpre_q + 4'd1;
                if (!i_binVal || xpre_d == cmax) begin
                    bin_idx_d = '0;
                    state_d   = S_YPRE;
                end
            end
            S_YPRE: if (i_bin_valid) begin
                bin_idx_d = bin_idx_q + 4'd1;
                if (i_binVal) ypre_d = ypre_q + 4'd1;
                if (!i_binVal || ypre_d == cmax) begin
                    bin_idx_d = '0;
                    if (xpre_q > 4'd3)      state_d = S_XSUF;
                    else if (ypre_d > 4'd3) state_d = S_YSUF;
                    else                    state_d = S_DONE;
                end
            end
            S_XSUF: if (i_byp_valid) begin
                xsuf_d    = {xsuf_q[1:0], i_byp_bin};
                suf_cnt_d = suf_cnt_q + 2'd1;
                if (suf_cnt_q == suf_len(xpre_q[3:1]) - 2'd1) begin
                    suf_cnt_d = '0;
                    state_d   = (ypre_q > 4'd3) ? S_YSUF : S_DONE;
                end
            end
            S_YSUF: if (i_byp_valid) begin
                ysuf_d    = {ysuf_q[1:0], i_byp_bin};
                suf_cnt_d = suf_cnt_q + 2'd1;
                if (suf_cnt_q == suf_len(ypre_q[3:1]) - 2'd1) begin
                    suf_cnt_d = '0;
                    state_d   = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Positions use next-state values so the final strobe's bit is included.
    assign pos_x = last_pos(xpre_d, xsuf_d);
    assign pos_y = last_pos(ypre_d, ysuf_d);

    always_comb begin
        last_x_d = last_x_q;
        last_y_d = last_y_q;
        if (state_d == S_DONE && state_q != S_DONE) begin
            last_x_d = swap_q ? pos_y : pos_x;
            last_y_d = swap_q ? pos_x : pos_y;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            log2_q    <= '0;
            chroma_q  <= 1'b0;
            swap_q    <= 1'b0;
            bin_idx_q <= '0;
            xpre_q    <= '0;
            ypre_q    <= '0;
            xsuf_q    <= '0;
            ysuf_q    <= '0;
            suf_cnt_q <= '0;
            last_x_q  <= '0;
            last_y_q  <= '0;
        end else begin
            state_q   <= state_d;
            log2_q    <= log2_d;
            chroma_q  <= chroma_d;
            swap_q    <= swap_d;
            bin_idx_q <= bin_idx_d;
            xpre_q    <= xpre_d;
            ypre_q    <= ypre_d;
            xsuf_q    <= xsuf_d;
            ysuf_q    <= ysuf_d;
            suf_cnt_q <= suf_cnt_d;
            last_x_q  <= last_x_d;
            last_y_q  <= last_y_d;
        end
    end

`ifdef DEC_LAST_XY_BINCNT_EN
    logic [4:0] bin_cnt_q, bin_cnt_d;
    logic       bin_acc;

    assign bin_acc   = (o_dec_en & i_bin_valid) | (o_byp_en & i_byp_valid);
    assign o_bin_cnt = bin_cnt_q;

    always_comb begin
        bin_cnt_d = bin_cnt_q;
        if (state_q == S_IDLE && i_start) bin_cnt_d = '0;
        else if (bin_acc)                 bin_cnt_d = bin_cnt_q + 5'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bin_cnt_q <= '0;
        else        bin_cnt_q <= bin_cnt_d;
    end
`endif

endmodule

// File: tb/tb_dec_last_sig_xy.sv
// Directed bench for dec_last_sig_xy: prefix/suffix sequencing, context indices, swap, wait states and reset.
module tb_dec_last_sig_xy;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_start = 1'b0;
    logic [2:0] i_log2TrafoSize = 3'd2;
    logic [1:0] i_cIdx = 2'd0;
    logic [1:0] i_scanIdx = 2'd0;
    logic       o_dec_en;
    logic [5:0] o_cm_idx;
    logic       i_bin_valid = 1'b0;
    logic       i_binVal = 1'b0;
    logic       o_byp_en;
    logic       i_byp_valid = 1'b0;
    logic       i_byp_bin = 1'b0;
    logic       o_busy;
    logic       o_done;
    logic [4:0] o_last_x;
    logic [4:0] o_last_y;
`ifdef DEC_LAST_XY_BINCNT_EN
    logic [4:0] o_bin_cnt;
`endif

    int total = 0;
    int bad = 0;
    int wcnt = 0;
    bit wmode = 0;
    bit noise = 0;

    dec_last_sig_xy dut (
        .clk(clk), .rst_n(rst_n), .i_start(i_start), .i_log2TrafoSize(i_log2TrafoSize),
        .i_cIdx(i_cIdx), .i_scanIdx(i_scanIdx), .o_dec_en(o_dec_en), .o_cm_idx(o_cm_idx),
        .i_bin_valid(i_bin_valid), .i_binVal(i_binVal), .o_byp_en(o_byp_en),
        .i_byp_valid(i_byp_valid), .i_byp_bin(i_byp_bin), .o_busy(o_busy), .o_done(o_done),
        .o_last_x(o_last_x), .o_last_y(o_last_y)
`ifdef DEC_LAST_XY_BINCNT_EN
        , .o_bin_cnt(o_bin_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [2:0] l2, input logic [1:0] ci, input logic [1:0] sc);
        i_start = 1'b1; i_log2TrafoSize = l2; i_cIdx = ci; i_scanIdx = sc;
        step();
        i_start = 1'b0;
        // Scrambled config shows it was sampled only on start.
        i_log2TrafoSize = 3'd2; i_cIdx = 2'd0; i_scanIdx = 2'd1;
        chk("start_busy", o_busy, 1);
        chk("start_dec_en", o_dec_en, 1);
    endtask

    task automatic idle_waits(input logic [5:0] exp_idx, input bit exp_dec);
        int w;
        w = wmode ? (wcnt % 4) : 0;
        wcnt++;
        for (int i = 0; i < w; i++) begin
            i_start = 1'b1;
            chk("wait_dec_en", o_dec_en, exp_dec);
            chk("wait_idx_hold", o_cm_idx, exp_idx);
            step();
        end
        i_start = 1'b0;
    endtask

    task automatic send_bin(input logic b, input logic [5:0] exp_idx);
        idle_waits(exp_idx, 1'b1);
        chk("bin_dec_en", o_dec_en, 1);
        chk("bin_byp_en", o_byp_en, 0);
        chk("cm_idx", o_cm_idx, exp_idx);
        i_bin_valid = 1'b1; i_binVal = b;
        i_byp_valid = noise; i_byp_bin = 1'b1;
        step();
        i_bin_valid = 1'b0; i_binVal = 1'b0; i_byp_valid = 1'b0; i_byp_bin = 1'b0;
    endtask

    task automatic send_byp(input logic b);
        idle_waits(6'd0, 1'b0);
        chk("byp_en", o_byp_en, 1);
        chk("byp_dec_en", o_dec_en, 0);
        chk("byp_cm_idx", o_cm_idx, 0);
        i_byp_valid = 1'b1; i_byp_bin = b;
        i_bin_valid = noise; i_binVal = 1'b1;
        step();
        i_byp_valid = 1'b0; i_byp_bin = 1'b0; i_bin_valid = 1'b0; i_binVal = 1'b0;
    endtask

    task automatic finish(input logic [4:0] ex, input logic [4:0] ey, input logic [4:0] ecnt);
        chk("done_pulse", o_done, 1);
        chk("done_busy", o_busy, 1);
        chk("done_dec_en", o_dec_en, 0);
        chk("done_byp_en", o_byp_en, 0);
        chk("last_x", o_last_x, ex);
        chk("last_y", o_last_y, ey);
`ifdef DEC_LAST_XY_BINCNT_EN
        chk("bin_cnt", o_bin_cnt, ecnt);
`else
        if (ecnt == 5'd31) $display("note: unexpected count");
`endif
        step();
        chk("done_clear", o_done, 0);
        chk("idle_busy", o_busy, 0);
        chk("held_x", o_last_x, ex);
        chk("held_y", o_last_y, ey);
    endtask

    task automatic run_32x32();
        start(3'd5, 2'd0, 2'd0);
        send_bin(1, 10); send_bin(1, 10); send_bin(1, 11); send_bin(1, 11); send_bin(1, 12);
        send_bin(1, 12); send_bin(1, 13); send_bin(1, 13); send_bin(1, 14);
        send_bin(0, 28);
        send_byp(1); send_byp(0); send_byp(1);
        finish(5'd29, 5'd0, 5'd13);
    endtask

    task automatic run_8x8c();
        start(3'd3, 2'd1, 2'd2);
        send_bin(1, 15); send_bin(1, 15); send_bin(1, 16); send_bin(1, 16); send_bin(1, 17);
        send_bin(1, 33); send_bin(0, 33);
        send_byp(1);
        finish(5'd1, 5'd7, 5'd8);
    endtask

    initial begin
        #2;
        chk("rst_dec_en", o_dec_en, 0);
        chk("rst_byp_en", o_byp_en, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        chk("rst_cm_idx", o_cm_idx, 0);
        chk("rst_last_x", o_last_x, 0);
        chk("rst_last_y", o_last_y, 0);
        step();
        rst_n = 1'b1;
        step();

        // 4x4 luma, minimum latency, stray bypass strobes alongside bins
        noise = 1;
        start(3'd2, 2'd0, 2'd0);
        send_bin(1, 0); send_bin(1, 1); send_bin(0, 2);
        send_bin(0, 18);
        finish(5'd2, 5'd0, 5'd4);
        noise = 0;

        run_32x32();
        run_8x8c();

        // Same decodes with idle cycles, ignored start pulses and cross strobes
        wmode = 1; noise = 1;
        run_32x32();
        run_8x8c();
        wmode = 0; noise = 0;

        // Reset in YPRE
        start(3'd2, 2'd0, 2'd0);
        send_bin(0, 0);
        chk("ypre_dec_en", o_dec_en, 1);
        chk("ypre_idx", o_cm_idx, 18);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dec_en", o_dec_en, 0);
        chk("arst_busy", o_busy, 0);
        chk("arst_idx", o_cm_idx, 0);
        chk("arst_last_x", o_last_x, 0);
        chk("arst_last_y", o_last_y, 0);
        step();
        rst_n = 1'b1;
        step();
        start(3'd2, 2'd0, 2'd0);
        send_bin(1, 0); send_bin(1, 1); send_bin(1, 2);
        send_bin(1, 18); send_bin(0, 19);
        finish(5'd3, 5'd1, 5'd5);

        // 16x16 luma, both suffixes, X first
        start(3'd4, 2'd0, 2'd0);
        send_bin(1, 6); send_bin(1, 6); send_bin(1, 7); send_bin(1, 7); send_bin(1, 8); send_bin(0, 8);
        send_bin(1, 24); send_bin(1, 24); send_bin(1, 25); send_bin(1, 25); send_bin(0, 26);
        send_byp(1);
        send_byp(0);
        finish(5'd7, 5'd4, 5'd13);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dec_last_sig_xy.md
# dec_last_sig_xy

Control stage directly downstream of the `last_sig_coeff_{x,y}_prefix` context-bin decoder in the H.265 CABAC residual path. For one transform block, it:
- sequences the context-coded prefix bins;
- drives the context index to the bin decoder;
- fetches the bypass suffix bits;
- produces LastSignificantCoeffX/Y, already swapped for vertical scan, for the residual-coding controller.

## Interface
- No parameters.
- `clk`  in  1  clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  one-cycle pulse; begins a decode. Ignored while `o_busy`=1.
- `i_log2TrafoSize`  in  3  2..5; sampled on accepted `i_start`.
- `i_cIdx`  in  2  0 = luma, 1/2 = chroma; sampled on start.
- `i_scanIdx`  in  2  2 = vertical scan (swap X/Y); sampled on start.
- `o_dec_en`  out  1  context-bin request to the prefix bin decoder.
- `o_cm_idx`  out  6  context index, 0..35. X uses 0..17, Y uses 18..35.
- `i_bin_valid`  in  1  one-cycle strobe; `i_binVal` is valid.
- `i_binVal`  in  1  decoded context bin.
- `o_byp_en`  out  1  bypass-bit request.
- `i_byp_valid`  in  1  one-cycle strobe; `i_byp_bin` is valid.
- `i_byp_bin`  in  1  decoded bypass bit.
- `o_busy`  out  1  high from the cycle after start until the `o_done` cycle inclusive.
- `o_done`  out  1  one-cycle pulse; results are valid.
- `o_last_x`  out  5  LastSignificantCoeffX, 0..31.
- `o_last_y`  out  5  LastSignificantCoeffY, 0..31.

## Operation
**States**
- **IDLE**
  - Accepted `i_start` latches the configuration.
  - Clears the bin counter and prefixes, then goes to XPRE.
- **XPRE, YPRE:** truncated-unary prefix.
  - `cMax` = 2·log2TrafoSize − 1.
  - `binIdx` counts accepted bins.
  - Each `i_bin_valid`=1 with bin 1 increments the prefix.
  - The state ends on bin 0, or when prefix == `cMax`; no terminating zero bin is requested.
  - XPRE goes to YPRE. YPRE goes to XSUF if xPrefix > 3, else YSUF if yPrefix > 3, else DONE.
- **XSUF, YSUF:** fixed-length bypass suffix, MSB first.
  - Length = (prefix >> 1) − 1 bits, so 1..3 bits.
  - XSUF goes to YSUF if yPrefix > 3, else DONE.
- **DONE**
  - `o_done`=1 for one cycle, then IDLE.

**Context index**
- Luma: ctxOffset = 3·(log2 − 2) + ((log2 − 1) >> 2), ctxShift = (log2 + 1) >> 2.
- Chroma: ctxOffset = 15, ctxShift = log2 − 2.
- `o_cm_idx` = (binIdx >> ctxShift) + ctxOffset, plus 18 in YPRE.
- `o_cm_idx` = 0 outside XPRE/YPRE.

**Final position**
- Prefix p ≤ 3: Last = p.
- Otherwise: Last = (1 << ((p >> 1) − 1))·(2 + (p & 1)) + suffix.
- If `i_scanIdx`=2, X and Y are swapped at output.
- `o_last_x`/`o_last_y` are registered in the DONE transition and held until the next accepted start.

**Boundary conditions**
- `i_bin_valid` outside XPRE/YPRE is ignored.
- `i_byp_valid` outside XSUF/YSUF is ignored.
- Both strobes high in the same cycle: only the one matching the current state counts.
- log2 = 5 with all-ones prefix gives p = 9 and a 3-bit suffix; maximum result is 31.
- Out-of-range `i_log2TrafoSize` (<2) is undefined and need not be checked.

## Timing
- **Reset values:** all outputs 0, state IDLE. Asserting `rst_n` mid-decode drops `o_dec_en`/`o_byp_en` immediately (asynchronous) and discards the partial result.
- **Start:** `i_start` at cycle T gives `o_busy`=1 and `o_dec_en`=1 at T+1, with a valid `o_cm_idx`.
- **Request lines:** `o_dec_en` and `o_byp_en` are level requests, high for the whole state. Only one request is ever outstanding.
- **Index stability:** `o_cm_idx` is stable while awaiting a bin. It updates the cycle after each accepted bin, so back-to-back strobes are allowed (one bin per cycle).
- **State change:** the request for the next state is asserted the cycle after the strobe that ends the current state.
- **Completion:** `o_done` occurs the cycle after the last strobe. Minimum latency is start + 3 cycles: two bins, no suffix, zero-wait strobes.
- **Restart:** a new `i_start` is accepted in the cycle following `o_done`.

## Configuration
- `DEC_LAST_XY_BINCNT_EN`
  - **Defined:** adds output `o_bin_cnt` (out, 5 bits), the total context plus bypass bins consumed in the last decode. Cleared on start, valid with `o_done`, reset 0.
  - **Undefined:** the port and counter are absent, and the block is otherwise identical.

## Test plan
- **4×4 luma, scan 0.**
  - Stimulus: X bins 1,1,0; Y bin 0.
  - Required: `o_cm_idx` sequence 0,1,2,18; no bypass requests; `o_last_x`=2, `o_last_y`=0.
- **32×32 luma.**
  - Stimulus: 9 ones in X; Y bin 0; bypass 1,0,1.
  - Required: `o_cm_idx` 10,10,11,11,12,12,13,13,14 then 28; `o_last_x`=29, `o_last_y`=0; `o_bin_cnt`=13 when enabled.
- **8×8 chroma, scanIdx=2.**
  - Stimulus: X bins 1,1,1,1,1; Y bins 1,0; bypass 1.
  - Required: `o_cm_idx` 15,15,16,16,17,33,33; unswapped (7,1), output `o_last_x`=1, `o_last_y`=7.
- **Wait states.**
  - Stimulus: insert 0–3 idle cycles before each strobe; pulse `i_start` during busy.
  - Required: `o_cm_idx` held steady while waiting; start ignored; results match the zero-wait run.
- **Reset mid-operation.**
  - Stimulus: deassert `rst_n` while in YPRE.
  - Required: same-cycle `o_dec_en`=0, outputs 0. After release, a fresh 4×4 decode gives the correct result.
- **Both prefixes > 3 (16×16 luma).**
  - Stimulus: X prefix 5, Y prefix 4; bypass 1 then 0.
  - Required: XSUF before YSUF; `o_last_x`=7, `o_last_y`=4.
